// File: rtl/c7bexu_lsu.sv
// c7bexu_lsu: single-outstanding load/store unit.
//
// Flow: IDLE captures an op from E, LS1 adds base+offset and checks
// alignment, LS2 presents one request on the valid/ready data bus, LS3
// waits for the response and produces exactly one end pulse.
//
// Ports:
//   clk, resetn            core clock, synchronous active-low reset
//   lsu_vld_e .. lsu_rd_e  memory op from E (sampled in IDLE only)
//   lsu_except_ale_ls1     misaligned-address pulse, lsu_badv_ls1 = address
//   lsu_data_valid_ls3     load complete, lsu_rdata_ls3 / lsu_rd_ls3 valid
//   lsu_wr_fin_ls3         store acknowledged
//   data_req .. data_wdata registered bus request
//   data_req_ready         bus accepts the request
//   data_rvalid/data_rdata bus response (read data or write ack)
module c7bexu_lsu (
  input  logic        clk,
  input  logic        resetn,
  input  logic        lsu_vld_e,
  input  logic [3:0]  lsu_op_e,
  input  logic [31:0] lsu_base_e,
  input  logic [31:0] lsu_offset_e,
  input  logic [31:0] lsu_wdata_e,
  input  logic [4:0]  lsu_rd_e,
  output logic        lsu_except_ale_ls1,
  output logic [31:0] lsu_badv_ls1,
  output logic        lsu_data_valid_ls3,
  output logic        lsu_wr_fin_ls3,
  output logic [31:0] lsu_rdata_ls3,
  output logic [4:0]  lsu_rd_ls3,
  output logic        data_req,
  output logic        data_wr,
  output logic [3:0]  data_be,
  output logic [31:0] data_addr,
  output logic [31:0] data_wdata,
  input  logic        data_req_ready,
  input  logic        data_rvalid,
  input  logic [31:0] data_rdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LS1  = 2'd1,
    S_LS2  = 2'd2,
    S_LS3  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [3:0]  op_p0;
  logic [31:0] base_p0;
  logic [31:0] off_p0;
  logic [31:0] wdata_p0;
  logic [4:0]  rd_p0;

  logic [31:0] addr_p1;
  logic        mis_p1;

  // Size encoding 2'b11 behaves as a word everywhere.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 1'b0;
      2'b01:   return a[0];
      default: return a != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return 4'b0011 << a;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] lane_rep(input logic [1:0] size, input logic [31:0] w);
    case (size)
      2'b00:   return {4{w[7:0]}};
      2'b01:   return {2{w[15:0]}};
      default: return w;
    endcase
  endfunction

  // Shift the addressed lane down to bit 0, then extend by load type.
  function automatic logic [31:0] load_extract(input logic [1:0] size, input logic uns,
                                               input logic [1:0] a, input logic [31:0] rdata);
    logic [31:0]        sh;
    logic signed [7:0]  b;
    logic signed [15:0] h;
    sh = rdata >> {a, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    case (size)
      2'b00:   return uns ? {24'h0, b} : 32'(b);
      2'b01:   return uns ? {16'h0, h} : 32'(h);
      default: return rdata;
    endcase
  endfunction

  // ---- E -> LS1: op capture (IDLE only) ----
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && lsu_vld_e) begin
      op_p0    <= lsu_op_e;
      base_p0  <= lsu_base_e;
      off_p0   <= lsu_offset_e;
      wdata_p0 <= lsu_wdata_e;
      rd_p0    <= lsu_rd_e;
    end
  end

  // ---- LS1: address generation and alignment check ----
  assign addr_p1 = base_p0 + off_p0;
  assign mis_p1  = misaligned(op_p0[1:0], addr_p1[1:0]);

  always_ff @(posedge clk) begin
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (lsu_vld_e) state_d = S_LS1;
      S_LS1:   state_d = mis_p1 ? S_IDLE : S_LS2;
      S_LS2:   if (data_req_ready) state_d = S_LS3;
      S_LS3:   if (data_rvalid) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---- LS1 -> LS2: registered bus request ----
  // data_addr is left intact after acceptance so LS3 can use its low bits
  // to pick the load lane.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_req   <= 1'b0;
      data_wr    <= 1'b0;
      data_be    <= 4'h0;
      data_addr  <= 32'h0;
      data_wdata <= 32'h0;
    end else if (state_q == S_LS1 && !mis_p1) begin
      data_req   <= 1'b1;
      data_wr    <= op_p0[3];
      data_be    <= byte_en(op_p0[1:0], addr_p1[1:0]);
      data_addr  <= addr_p1;
      data_wdata <= lane_rep(op_p0[1:0], wdata_p0);
    end else if (state_q == S_LS2 && data_req_ready) begin
      data_req   <= 1'b0;
    end
  end

  // ---- LS3: response and end pulses ----
  always_comb begin
    lsu_except_ale_ls1 = (state_q == S_LS1) && mis_p1;
    lsu_badv_ls1       = lsu_except_ale_ls1 ? addr_p1 : 32'h0;
    lsu_data_valid_ls3 = (state_q == S_LS3) && data_rvalid && !op_p0[3];
    lsu_wr_fin_ls3     = (state_q == S_LS3) && data_rvalid && op_p0[3];
    lsu_rdata_ls3      = 32'h0;
    lsu_rd_ls3         = 5'h0;
    if (lsu_data_valid_ls3) begin
      lsu_rdata_ls3 = load_extract(op_p0[1:0], op_p0[2], data_addr[1:0], data_rdata);
      lsu_rd_ls3    = rd_p0;
    end
  end

endmodule

// File: tb/tb_c7bexu_lsu.sv
module tb_c7bexu_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        lsu_vld_e;
  logic [3:0]  lsu_op_e;
  logic [31:0] lsu_base_e, lsu_offset_e, lsu_wdata_e;
  logic [4:0]  lsu_rd_e;
  logic        lsu_except_ale_ls1;
  logic [31:0] lsu_badv_ls1;
  logic        lsu_data_valid_ls3, lsu_wr_fin_ls3;
  logic [31:0] lsu_rdata_ls3;
  logic [4:0]  lsu_rd_ls3;
  logic        data_req, data_wr;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata;
  logic        data_req_ready, data_rvalid;
  logic [31:0] data_rdata;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_load;
    logic [31:0] rdata;
    logic [4:0]  rd;
  } exp_t;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  c7bexu_lsu dut (
    .clk(clk), .resetn(resetn),
    .lsu_vld_e(lsu_vld_e), .lsu_op_e(lsu_op_e), .lsu_base_e(lsu_base_e),
    .lsu_offset_e(lsu_offset_e), .lsu_wdata_e(lsu_wdata_e), .lsu_rd_e(lsu_rd_e),
    .lsu_except_ale_ls1(lsu_except_ale_ls1), .lsu_badv_ls1(lsu_badv_ls1),
    .lsu_data_valid_ls3(lsu_data_valid_ls3), .lsu_wr_fin_ls3(lsu_wr_fin_ls3),
    .lsu_rdata_ls3(lsu_rdata_ls3), .lsu_rd_ls3(lsu_rd_ls3),
    .data_req(data_req), .data_wr(data_wr), .data_be(data_be),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_req_ready(data_req_ready), .data_rvalid(data_rvalid), .data_rdata(data_rdata)
  );

  // Reference model
  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [3:0] m_be(input logic [1:0] size, input int a);
    logic [3:0] be;
    int n;
    n = nbytes(size);
    for (int i = 0; i < 4; i++) be[i] = (i >= a) && (i < a + n);
    return be;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [1:0] size, input logic [31:0] w);
    logic [31:0] r;
    int n;
    n = nbytes(size);
    for (int i = 0; i < 4; i++) r[8*i +: 8] = w[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_load(input logic [1:0] size, input logic uns,
                                         input int a, input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a);
    case (nbytes(size))
      1:       v = uns ? {24'h0, v[7:0]}  : {{24{v[7]}}, v[7:0]};
      2:       v = uns ? {16'h0, v[15:0]} : {{16{v[15]}}, v[15:0]};
      default: v = rd;
    endcase
    return v;
  endfunction

  // Scoreboard consumer: every end pulse pops and checks one expectation.
  always begin
    exp_t e;
    @(negedge clk);
    #4;
    if (lsu_data_valid_ls3 || lsu_wr_fin_ls3) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++;
        $display("FAIL sb_unexpected_pulse: got dv=%0b wf=%0b, required no pulse",
                 lsu_data_valid_ls3, lsu_wr_fin_ls3);
      end else begin
        e = sb_q.pop_front();
        total++;
        if ({lsu_data_valid_ls3, lsu_wr_fin_ls3} !== {e.is_load, !e.is_load}) begin
          bad++;
          $display("FAIL sb_kind: got dv=%0b wf=%0b, required load=%0b",
                   lsu_data_valid_ls3, lsu_wr_fin_ls3, e.is_load);
        end
        if (e.is_load) begin
          total++;
          if (lsu_rdata_ls3 !== e.rdata) begin
            bad++;
            $display("FAIL sb_rdata: got %h, required %h", lsu_rdata_ls3, e.rdata);
          end
          total++;
          if (lsu_rd_ls3 !== e.rd) begin
            bad++;
            $display("FAIL sb_rd: got %0d, required %0d", lsu_rd_ls3, e.rd);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  // Drive an op in IDLE; returns at the LS1 negedge.
  task automatic start_op(input logic [3:0] op, input logic [31:0] b, input logic [31:0] o,
                          input logic [31:0] w, input logic [4:0] rd);
    @(negedge clk);
    data_rvalid  = 1'b0;
    lsu_vld_e    = 1'b1;
    lsu_op_e     = op;
    lsu_base_e   = b;
    lsu_offset_e = o;
    lsu_wdata_e  = w;
    lsu_rd_e     = rd;
    @(negedge clk);
    lsu_vld_e    = 1'b0;
  endtask

  // Called at an LS2 negedge; returns at the LS3 negedge.
  task automatic accept(input int delay);
    repeat (delay) @(negedge clk);
    data_req_ready = 1'b1;
    @(negedge clk);
    data_req_ready = 1'b0;
  endtask

  task automatic respond(input logic [31:0] rd);
    data_rvalid = 1'b1;
    data_rdata  = rd;
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({data_req, data_wr, data_be, data_addr, data_wdata, lsu_except_ale_ls1, lsu_badv_ls1,
         lsu_data_valid_ls3, lsu_wr_fin_ls3, lsu_rdata_ls3, lsu_rd_ls3} !== '0) begin
      bad++;
      $display("FAIL reset_outputs: got req=%b be=%h addr=%h ale=%b dv=%b, required all 0",
               data_req, data_be, data_addr, lsu_except_ale_ls1, lsu_data_valid_ls3);
    end
    resetn = 1'b1;
  endtask

  task automatic test_load_word;
    sb_q.push_back('{1'b1, 32'hDEADBEEF, 5'd3});
    start_op(4'b0010, 32'h1000, 32'd4, 32'h0, 5'd3);
    total++;
    if (lsu_except_ale_ls1 !== 1'b0) begin
      bad++; $display("FAIL lw_ale: got %b, required 0", lsu_except_ale_ls1);
    end
    @(negedge clk);
    total++;
    if ({data_req, data_wr, data_be, data_addr} !== {1'b1, 1'b0, 4'b1111, 32'h1004}) begin
      bad++;
      $display("FAIL lw_bus: got req=%b wr=%b be=%b addr=%h, required 1 0 1111 00001004",
               data_req, data_wr, data_be, data_addr);
    end
    accept(0);
    total++;
    if (data_req !== 1'b0) begin
      bad++; $display("FAIL lw_req_drop: got %b, required 0", data_req);
    end
    respond(32'hDEADBEEF);
    total++;
    if (lsu_data_valid_ls3 !== 1'b1) begin
      bad++; $display("FAIL lw_dv_cycle3: got %b, required 1", lsu_data_valid_ls3);
    end
    @(negedge clk);
    data_rvalid = 1'b0;
    total++;
    if (lsu_data_valid_ls3 !== 1'b0) begin
      bad++; $display("FAIL lw_dv_single: got %b, required 0", lsu_data_valid_ls3);
    end
  endtask

  task automatic test_load_byte;
    for (int u = 0; u < 2; u++) begin
      sb_q.push_back('{1'b1, (u == 0) ? 32'hFFFFFF80 : 32'h00000080, 5'd7});
      start_op({1'b0, u[0], 2'b00}, 32'h2000, 32'd3, 32'h0, 5'd7);
      @(negedge clk);
      total++;
      if ({data_be, data_addr} !== {4'b1000, 32'h2003}) begin
        bad++;
        $display("FAIL lb_bus: got be=%b addr=%h, required 1000 00002003", data_be, data_addr);
      end
      accept(0);
      respond(32'h80FFFFFF);
    end
    @(negedge clk);
    data_rvalid = 1'b0;
  endtask

  task automatic test_store_half;
    sb_q.push_back('{1'b0, 32'h0, 5'd0});
    start_op(4'b1001, 32'h3000, 32'd2, 32'h0000ABCD, 5'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      total++;
      if ({data_req, data_wr, data_be, data_addr, data_wdata} !==
          {1'b1, 1'b1, 4'b1100, 32'h3002, 32'hABCDABCD}) begin
        bad++;
        $display("FAIL sh_hold: cycle %0d got req=%b wr=%b be=%b addr=%h wd=%h, required 1 1 1100 00003002 abcdabcd",
                 c, data_req, data_wr, data_be, data_addr, data_wdata);
      end
    end
    accept(0);
    respond(32'h12345678);
    total++;
    if ({lsu_wr_fin_ls3, lsu_data_valid_ls3} !== 2'b10) begin
      bad++;
      $display("FAIL sh_pulses: got wf=%b dv=%b, required 1 0", lsu_wr_fin_ls3, lsu_data_valid_ls3);
    end
    @(negedge clk);
    data_rvalid = 1'b0;
  endtask

  task automatic test_misaligned;
    start_op(4'b0010, 32'hFFFFFFFF, 32'd3, 32'h0, 5'd1);
    total++;
    if ({lsu_except_ale_ls1, lsu_badv_ls1} !== {1'b1, 32'h00000002}) begin
      bad++;
      $display("FAIL mis_word: got ale=%b badv=%h, required 1 00000002", lsu_except_ale_ls1, lsu_badv_ls1);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      total++;
      if ({data_req, lsu_except_ale_ls1, lsu_badv_ls1} !== '0) begin
        bad++;
        $display("FAIL mis_quiet: cycle %0d got req=%b ale=%b badv=%h, required 0",
                 c, data_req, lsu_except_ale_ls1, lsu_badv_ls1);
      end
    end
    start_op(4'b0101, 32'h10, 32'd1, 32'h0, 5'd1);
    total++;
    if ({lsu_except_ale_ls1, lsu_badv_ls1} !== {1'b1, 32'h00000011}) begin
      bad++;
      $display("FAIL mis_half: got ale=%b badv=%h, required 1 00000011", lsu_except_ale_ls1, lsu_badv_ls1);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_midop;
    start_op(4'b0010, 32'h4000, 32'd0, 32'h0, 5'd9);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    total++;
    if (data_req !== 1'b0) begin
      bad++; $display("FAIL rst_ls2_req: got %b, required 0", data_req);
    end
    start_op(4'b0010, 32'h4000, 32'd8, 32'h0, 5'd9);
    @(negedge clk);
    accept(1);
    resetn = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    respond(32'hCAFEF00D);
    total++;
    if ({data_req, data_wr, data_be, data_addr, data_wdata, lsu_except_ale_ls1, lsu_badv_ls1,
         lsu_data_valid_ls3, lsu_wr_fin_ls3, lsu_rdata_ls3, lsu_rd_ls3} !== '0) begin
      bad++;
      $display("FAIL rst_ls3: got req=%b addr=%h dv=%b wf=%b rdata=%h, required all 0",
               data_req, data_addr, lsu_data_valid_ls3, lsu_wr_fin_ls3, lsu_rdata_ls3);
    end
    @(negedge clk);
    data_rvalid = 1'b0;
    sb_q.push_back('{1'b1, 32'h0000BEEF, 5'd12});
    start_op(4'b0101, 32'h5000, 32'd2, 32'h0, 5'd12);
    @(negedge clk);
    accept(0);
    respond(32'hBEEF1234);
    total++;
    if (lsu_data_valid_ls3 !== 1'b1) begin
      bad++; $display("FAIL rst_recover: got dv=%b, required 1", lsu_data_valid_ls3);
    end
    @(negedge clk);
    data_rvalid = 1'b0;
  endtask

  task automatic test_ignored_inputs;
    sb_q.push_back('{1'b1, 32'h01020304, 5'd4});
    start_op(4'b0010, 32'h6000, 32'd0, 32'h0, 5'd4);
    @(negedge clk);
    lsu_vld_e = 1'b1; lsu_op_e = 4'b1000; lsu_base_e = 32'h7000; lsu_rd_e = 5'd20;
    @(negedge clk);
    lsu_vld_e = 1'b0;
    total++;
    if ({data_req, data_wr, data_addr} !== {1'b1, 1'b0, 32'h6000}) begin
      bad++;
      $display("FAIL ign_vld_ls2: got req=%b wr=%b addr=%h, required 1 0 00006000", data_req, data_wr, data_addr);
    end
    accept(0);
    respond(32'h01020304);
    @(negedge clk);
    data_rvalid = 1'b0;
    respond(32'hFFFFFFFF);
    total++;
    if ({lsu_data_valid_ls3, lsu_wr_fin_ls3, data_req} !== 3'b000) begin
      bad++;
      $display("FAIL ign_rvalid_idle: got dv=%b wf=%b req=%b, required 0 0 0",
               lsu_data_valid_ls3, lsu_wr_fin_ls3, data_req);
    end
    @(negedge clk);
    data_rvalid = 1'b0;
    @(negedge clk);
    total++;
    if ({data_req, lsu_except_ale_ls1} !== 2'b00) begin
      bad++; $display("FAIL ign_idle: got req=%b ale=%b, required 0 0", data_req, lsu_except_ale_ls1);
    end
  endtask

  // Back-to-back ops over every size, extension and aligned lane.
  task automatic test_back_to_back;
    logic [31:0] addr, off, rdat, wd;
    logic [4:0]  rd;
    logic [3:0]  op;
    for (int s = 0; s < 3; s++)
      for (int st = 0; st < 2; st++)
        for (int u = 0; u < 2; u++)
          for (int a = 0; a < 4; a++) begin
            if (s == 1 && a[0]) continue;
            if (s == 2 && a != 0) continue;
            if ((st == 1 || s == 2) && u == 1) continue;
            op   = {st[0], u[0], s[1:0]};
            addr = ($urandom() & 32'hFFFF_FFFC) | a;
            off  = $urandom();
            wd   = $urandom();
            rdat = $urandom();
            rd   = 5'($urandom_range(0, 31));
            sb_q.push_back('{(st == 0), m_load(s[1:0], u[0], a, rdat), rd});
            start_op(op, addr - off, off, wd, rd);
            total++;
            if (lsu_except_ale_ls1 !== 1'b0) begin
              bad++; $display("FAIL b2b_ale: op=%b got %b, required 0", op, lsu_except_ale_ls1);
            end
            @(negedge clk);
            total++;
            if ({data_req, data_wr, data_be, data_addr} !== {1'b1, st[0], m_be(s[1:0], a), addr}) begin
              bad++;
              $display("FAIL b2b_bus: op=%b got req=%b wr=%b be=%b addr=%h, required 1 %b %b %h",
                       op, data_req, data_wr, data_be, data_addr, st[0], m_be(s[1:0], a), addr);
            end
            if (st == 1) begin
              total++;
              if (data_wdata !== m_wdata(s[1:0], wd)) begin
                bad++;
                $display("FAIL b2b_wdata: op=%b got %h, required %h", op, data_wdata, m_wdata(s[1:0], wd));
              end
            end
            accept($urandom_range(0, 2));
            respond(rdat);
          end
    @(negedge clk);
    data_rvalid = 1'b0;
  endtask

  initial begin
    resetn = 1'b0; lsu_vld_e = 1'b0; lsu_op_e = 4'h0; lsu_base_e = 32'h0;
    lsu_offset_e = 32'h0; lsu_wdata_e = 32'h0; lsu_rd_e = 5'h0;
    data_req_ready = 1'b0; data_rvalid = 1'b0; data_rdata = 32'h0;
    test_reset;
    test_load_word;
    test_load_byte;
    test_store_half;
    test_misaligned;
    test_reset_midop;
    test_ignored_inputs;
    test_back_to_back;
    repeat (2) @(negedge clk);
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_leftover: got %0d pending, required 0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
